// File: rtl/icache_if.sv
// Fetch/refill bus of the instruction cache.
// The master side is the fetch stage together with backing memory.
// The slave side is the cache itself.
interface icache_if;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        stallI;
    logic        invalidate;
    logic        memreq;
    logic [31:0] memaddr;
    logic [31:0] memrdata;
    logic        memvalid;

    modport master (
        output pcF, invalidate, memrdata, memvalid,
        input  instrF, stallI, memreq, memaddr
    );

    modport slave (
        input  pcF, invalidate, memrdata, memvalid,
        output instrF, stallI, memreq, memaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// Hits return the instruction combinationally in the same cycle.
// A miss stalls fetch while the refill FSM pulls the whole line from
// backing memory, one word per memvalid beat.
module icache #(
    parameter int NLINES = 16,
    parameter int WORDS  = 4
) (
    input  logic     clk,
    input  logic     reset,
    icache_if.slave  bus
);
    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(NLINES);
    localparam int TB = 30 - OB - IB;
    localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t            state, state_next;
    logic [NLINES-1:0] valid;
    logic [TB-1:0]     tag_mem  [NLINES];
    logic [31:0]       data_mem [NLINES][WORDS];

    logic [TB+IB-1:0]  miss_addr, miss_addr_next;
    logic [OB-1:0]     beat, beat_next;
    logic              pending, pending_next;
    logic              req, req_next;
    logic [31:0]       addr, addr_next;
    logic              consume, complete, hit;

    logic [OB-1:0]     offset;
    logic [IB-1:0]     index, miss_index;
    logic [TB-1:0]     tag, miss_tag;
    logic [1:0]        unused_pc_bits;

    assign offset         = bus.pcF[OB+1:2];
    assign index          = bus.pcF[OB+IB+1:OB+2];
    assign tag            = bus.pcF[31:OB+IB+2];
    assign unused_pc_bits = bus.pcF[1:0];
    assign miss_index     = miss_addr[IB-1:0];
    assign miss_tag       = miss_addr[TB+IB-1:IB];

    // Hit lookup; anything that is not a hit in IDLE stalls fetch and returns 0
    always_comb begin
        hit        = (state == IDLE) && valid[index] && (tag_mem[index] == tag);
        bus.stallI = !hit;
        bus.instrF = hit ? data_mem[index][offset] : 32'h0;
    end

    // Refill FSM next-state logic, beat bookkeeping and the next request/address
    always_comb begin
        state_next     = state;
        miss_addr_next = miss_addr;
        beat_next      = beat;
        pending_next   = pending;
        addr_next      = addr;
        consume        = 1'b0;
        complete       = 1'b0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    state_next     = REFILL;
                    miss_addr_next = {tag, index};
                    beat_next      = '0;
                    addr_next      = {tag, index, {OB{1'b0}}, 2'b00};
                end
            end
            REFILL: begin
                if (bus.invalidate) begin
                    pending_next = 1'b1;
                end
                if (bus.memvalid) begin
                    consume = 1'b1;
                    if (beat == LAST_BEAT) begin
                        complete     = 1'b1;
                        beat_next    = '0;
                        pending_next = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        beat_next = beat + OB'(1);
                    end
                    addr_next = {miss_addr, beat_next, 2'b00};
                end
            end
            default: state_next = IDLE;
        endcase
        req_next = (state_next == REFILL);
    end

    // State register plus the registered memory request and beat address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            miss_addr <= '0;
            beat      <= '0;
            pending   <= 1'b0;
            req       <= 1'b0;
            addr      <= '0;
        end else begin
            state     <= state_next;
            miss_addr <= miss_addr_next;
            beat      <= beat_next;
            pending   <= pending_next;
            req       <= req_next;
            addr      <= addr_next;
        end
    end

    assign bus.memreq  = req;
    assign bus.memaddr = addr;

    // Valid bits: flash-clear on invalidate, set only when a clean refill finishes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (state == IDLE && bus.invalidate) begin
            valid <= '0;
        end else if (complete) begin
            if (pending || bus.invalidate) begin
                valid <= '0;
            end else begin
                valid[miss_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid alone decides visibility
    always_ff @(posedge clk) begin
        if (consume) begin
            data_mem[miss_index][beat] <= bus.memrdata;
        end
        if (complete) begin
            tag_mem[miss_index] <= miss_tag;
        end
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetch-stage PC register and the decode-stage instruction register. Hits return `instrF` combinationally in the same cycle. A miss raises `stallI`, which the hazard logic ORs into `stallF`/`stallD`. On a miss, a refill FSM fetches the whole line from backing memory over a word-per-beat valid handshake.

## Interface
- `NLINES`, default 16: number of lines; power of two, ≥2.
- `WORDS`, default 4: 32-bit words per line; power of two, ≥2.
- Derived widths:
  - OB = log2(WORDS): offset bits.
  - IB = log2(NLINES): index bits.
  - TB = 30−OB−IB: tag bits.
- Address split of `pcF`:
  - [1:0]: ignored.
  - [OB+1:2]: word offset.
  - [OB+IB+1:OB+2]: index.
  - [31:OB+IB+2]: tag.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pcF`  in  32  fetch address.
- `instrF`  out  32  instruction word; 0 whenever `stallI`=1.
- `stallI`  out  1  miss stall, combinational.
- `invalidate`  in  1  single-cycle pulse; clears all valid bits.
- `memreq`  out  1  refill request, registered.
- `memaddr`  out  32  word address of the current refill beat, registered.
- `memrdata`  in  32  refill data.
- `memvalid`  in  1  `memrdata` is valid this cycle; ignored while `memreq`=0.

## Operation
- Storage per line: valid bit, TB-bit tag, WORDS×32 data words.
- Hit condition: state IDLE, valid[index]=1, tag[index]=tag(pcF).
  - On hit: `instrF`=data[index][offset], `stallI`=0.
- Any other condition drives `stallI`=1 and `instrF`=0. This includes every cycle spent in REFILL.
- FSM states:
  - IDLE: on a miss, latch {tag, index} of `pcF` into `missaddr`, clear beat counter, go to REFILL.
  - REFILL: `memreq`=1, `memaddr`={missaddr, beat, 2'b00}.
    - On each `memvalid`, write `memrdata` into data[index][beat] and increment beat.
    - On the beat where beat=WORDS−1 and `memvalid`=1: write tag[index], set valid[index] (unless an invalidate is pending), wrap beat to 0, go to IDLE.
- `memaddr` advances to the next beat address on the edge that consumes a beat. Between beats with `memvalid`=0 it holds its value.
- A refill overwrites the resident line unconditionally. There are no dirty lines (read-only cache).
- `invalidate` handling:
  - In IDLE: all valid bits clear at the next edge. A hit in that same cycle is still served.
  - In REFILL: latched into a pending flag. At refill completion all valid bits clear, the refilled line stays invalid, and the flag clears.
  - Invalidate arriving on the completing beat is handled the same way as one during REFILL.
- The fetched PC need not be held stable during REFILL; the refill uses `missaddr`.
- Data writes of partial refills persist but are never visible until valid is set.

## Timing
- Reset values:
  - state IDLE, all valid=0, beat=0, pending=0.
  - `memreq`=0, `memaddr`=0.
  - `stallI`=1 and `instrF`=0 while any `pcF` misses, which is all addresses after reset.
- Tag and data arrays need not be reset.
- Hit latency: 0 cycles (same-cycle combinational).
- Miss timeline, with the miss seen in cycle 0:
  - Cycle 0: `stallI`=1, `memreq`=0.
  - Cycle 1: `memreq`=1, `memaddr`=line base.
  - With `memvalid` held high from cycle 1, beats are consumed in cycles 1..WORDS.
  - Cycle WORDS+1: IDLE, `memreq`=0, hit, `stallI`=0.
  - Minimum miss penalty: WORDS+1 stall cycles (5 at default).
- Each `memvalid` gap cycle adds exactly one stall cycle.
- Reset asserted mid-refill:
  - Returns immediately to the reset values.
  - The partially filled line remains invalid.
  - `memreq` drops asynchronously.

## Test plan
- Cold miss: reset, `pcF`=0x0, `memvalid`=1 every cycle with `memrdata`=0x1000+beat.
  - `memreq` high cycles 1–4.
  - `memaddr` 0x0, 0x4, 0x8, 0xC.
  - `stallI` high cycles 0–4.
  - Cycle 5: `instrF`=0x1000.
- Same-line hits after the cold miss: `pcF`=0x4, 0x8, 0xC on consecutive cycles.
  - `stallI`=0.
  - `instrF`=0x1001, 0x1002, 0x1003.
  - `memreq` stays 0.
- Gapped refill: miss at 0x40 with `memvalid` pattern 1,0,0,1,1,0,1.
  - `memaddr` holds during gaps.
  - `stallI` falls exactly one cycle after the fourth valid beat.
- Conflict miss: after 0x0 is filled, fetch 0x100 (index 0, new tag).
  - Refill occurs from 0x100.
  - A following fetch of 0x0 misses again.
- Invalidate:
  - Pulse in IDLE: the next fetch of 0x0 misses.
  - Pulse during a refill of 0x40: the refill completes, the next fetch of 0x40 misses again, and 0x0 also misses.
- Reset mid-refill: assert `reset` after two beats of the 0x80 refill.
  - `memreq`=0 and `memaddr`=0 immediately.
  - After release, the fetch of 0x80 misses and performs a full 4-beat refill.
